// File: rtl/dmem_access_controller_if.sv
// Word-wide data-memory bus between the access controller (master) and the data memory (slave).
// Strobes are held high until the single-cycle ack.
interface dmem_access_controller_if;
    logic        dmem_read;
    logic        dmem_write;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_byte_en;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;

    modport master (
        output dmem_read, dmem_write, dmem_addr, dmem_wdata, dmem_byte_en,
        input  dmem_rdata, dmem_ack
    );

    modport slave (
        input  dmem_read, dmem_write, dmem_addr, dmem_wdata, dmem_byte_en,
        output dmem_rdata, dmem_ack
    );
endinterface

// File: rtl/dmem_access_controller.sv
// MEM-stage load/store sequencer for a multi-cycle word-wide data memory.
// It aligns stores to byte lanes, extends loads, stalls the pipeline and reports access faults.
module dmem_access_controller #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            mem_read_i,
    input  logic                            mem_write_i,
    input  logic [2:0]                      func3_i,
    input  logic [31:0]                     address_i,
    input  logic [31:0]                     data2_i,
    output logic [31:0]                     data_out_o,
    output logic                            busywait_o,
    output logic                            fault_o,
    output logic [1:0]                      fault_cause_o,
    dmem_access_controller_if.master        dmem
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_e;

    localparam logic [7:0] TIMEOUT_LIMIT  = 8'(TIMEOUT_CYCLES);
    localparam logic [1:0] CAUSE_NONE     = 2'b00;
    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_ILLEGAL  = 2'b10;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

    function automatic logic [31:0] extend_load(input logic [2:0] f3, input logic [1:0] a,
                                                input logic [31:0] rdata);
        logic [31:0] lane_s;
        logic [31:0] half_s;
        logic [31:0] res_s;
        lane_s = rdata >> {a, 3'b000};
        half_s = rdata >> {a[1], 4'b0000};
        case (f3)
            3'b000:  res_s = {{24{lane_s[7]}}, lane_s[7:0]};
            3'b100:  res_s = {24'h000000, lane_s[7:0]};
            3'b001:  res_s = {{16{half_s[15]}}, half_s[15:0]};
            3'b101:  res_s = {16'h0000, half_s[15:0]};
            default: res_s = rdata;
        endcase
        return res_s;
    endfunction

    function automatic logic [31:0] align_store(input logic [2:0] f3, input logic [31:0] d);
        case (f3[1:0])
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [3:0] store_lanes(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b00:   return 4'b0001 << a;
            2'b01:   return 4'b0011 << {a[1], 1'b0};
            2'b10:   return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    state_e      state_q, state_d;
    logic        store_q, store_d;
    logic [2:0]  func3_q, func3_d;
    logic [1:0]  alo_q, alo_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        timeout_q, timeout_d;
    logic [31:0] data_out_q, data_out_d;
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  ben_q, ben_d;

    logic        req_s, illegal_s, misalign_s, busy_s, fault_s;
    logic [1:0]  cause_s;

    assign req_s      = mem_read_i | mem_write_i;
    assign illegal_s  = (func3_i == 3'b011) | (func3_i == 3'b110) | (func3_i == 3'b111)
                      | (mem_write_i & func3_i[2]);
    assign misalign_s = ((func3_i[1:0] == 2'b01) & address_i[0])
                      | ((func3_i == 3'b010) & (address_i[1:0] != 2'b00));

    // Next-state, latched access context and stall/fault outputs.
    always_comb begin
        state_d    = state_q;
        store_d    = store_q;
        func3_d    = func3_q;
        alo_d      = alo_q;
        cnt_d      = cnt_q;
        timeout_d  = timeout_q;
        data_out_d = data_out_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        ben_d      = ben_q;
        busy_s     = 1'b0;
        fault_s    = 1'b0;
        cause_s    = CAUSE_NONE;
        case (state_q)
            S_IDLE: begin
                timeout_d = 1'b0;
                if (req_s && illegal_s) begin
                    fault_s = 1'b1;
                    cause_s = CAUSE_ILLEGAL;
                end else if (req_s && misalign_s) begin
                    fault_s = 1'b1;
                    cause_s = CAUSE_MISALIGN;
                end else if (req_s) begin
                    busy_s  = 1'b1;
                    state_d = S_ACCESS;
                    store_d = mem_write_i;
                    func3_d = func3_i;
                    alo_d   = address_i[1:0];
                    addr_d  = {address_i[31:2], 2'b00};
                    wdata_d = mem_write_i ? align_store(func3_i, data2_i) : 32'h0000_0000;
                    ben_d   = mem_write_i ? store_lanes(func3_i, address_i[1:0]) : 4'b0000;
                    rd_d    = ~mem_write_i;
                    wr_d    = mem_write_i;
                    cnt_d   = 8'd0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ACCESS: begin
                busy_s = 1'b1;
                cnt_d  = cnt_q + 8'd1;
                // Ack beats a timeout that lands in the same cycle.
                if (dmem.dmem_ack) begin
                    rd_d       = 1'b0;
                    wr_d       = 1'b0;
                    state_d    = S_DONE;
                    data_out_d = store_q ? data_out_q : extend_load(func3_q, alo_q, dmem.dmem_rdata);
                end else if ((cnt_q + 8'd1) == TIMEOUT_LIMIT) begin
                    rd_d      = 1'b0;
                    wr_d      = 1'b0;
                    timeout_d = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    state_d = S_ACCESS;
                end
            end
            S_DONE: begin
                fault_s = timeout_q;
                cause_s = timeout_q ? CAUSE_TIMEOUT : CAUSE_NONE;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and access registers; the asynchronous reset drops the memory strobes immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            store_q    <= 1'b0;
            func3_q    <= 3'b000;
            alo_q      <= 2'b00;
            cnt_q      <= 8'd0;
            timeout_q  <= 1'b0;
            data_out_q <= 32'h0000_0000;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            addr_q     <= 32'h0000_0000;
            wdata_q    <= 32'h0000_0000;
            ben_q      <= 4'b0000;
        end else begin
            state_q    <= state_d;
            store_q    <= store_d;
            func3_q    <= func3_d;
            alo_q      <= alo_d;
            cnt_q      <= cnt_d;
            timeout_q  <= timeout_d;
            data_out_q <= data_out_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            ben_q      <= ben_d;
        end
    end

    // Stall and fault are combinational, so reset masks them directly.
    assign busywait_o        = busy_s & ~rst;
    assign fault_o           = fault_s & ~rst;
    assign fault_cause_o     = rst ? CAUSE_NONE : cause_s;
    assign data_out_o        = data_out_q;
    assign dmem.dmem_read    = rd_q;
    assign dmem.dmem_write   = wr_q;
    assign dmem.dmem_addr    = addr_q;
    assign dmem.dmem_wdata   = wdata_q;
    assign dmem.dmem_byte_en = ben_q;

endmodule

// File: tb/tb_dmem_access_controller.sv
// Randomised and directed bench for dmem_access_controller against a behavioural access model.
// The bench acts as the data memory and chooses the ack latency of every access.
module tb_dmem_access_controller;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read, mem_write;
    logic [2:0]  func3;
    logic [31:0] address, data2;
    logic [31:0] data_out;
    logic        busywait, fault;
    logic [1:0]  fault_cause;
    int          tests_run = 0;
    int          tests_failed = 0;
    int          cyc = 0;
    logic [31:0] exp_data_out;

    dmem_access_controller_if bus ();

    dmem_access_controller #(.TIMEOUT_CYCLES(TO)) dut (
        .clk           (clk),
        .rst           (rst),
        .mem_read_i    (mem_read),
        .mem_write_i   (mem_write),
        .func3_i       (func3),
        .address_i     (address),
        .data2_i       (data2),
        .data_out_o    (data_out),
        .busywait_o    (busywait),
        .fault_o       (fault),
        .fault_cause_o (fault_cause),
        .dmem          (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    function automatic bit model_illegal(bit store, logic [2:0] f3);
        return !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) || (store && f3 >= 3'd4);
    endfunction

    function automatic bit model_misaligned(logic [2:0] f3, logic [31:0] addr);
        int unsigned size = 32'd1 << f3[1:0];
        return (addr % size) != 0;
    endfunction

    function automatic logic [31:0] model_load(logic [2:0] f3, logic [31:0] addr, logic [31:0] rdata);
        longint unsigned width = 64'd8 << f3[1:0];
        longint unsigned v;
        v = (longint'(rdata) >> (8 * (addr % 4))) & ((64'd1 << width) - 64'd1);
        if (f3[2] == 1'b0 && width < 32 && ((v >> (width - 1)) & 64'd1) == 64'd1)
            v = v - (64'd1 << width);
        return v[31:0];
    endfunction

    function automatic logic [31:0] model_wdata(logic [2:0] f3, logic [31:0] d);
        case (f3[1:0])
            2'd0:    return 32'(d[7:0]) * 32'h0101_0101;
            2'd1:    return 32'(d[15:0]) * 32'h0001_0001;
            default: return d;
        endcase
    endfunction

    function automatic logic [3:0] model_ben(logic [2:0] f3, logic [31:0] addr);
        case (f3[1:0])
            2'd0:    return 4'(32'd1 << (addr % 4));
            2'd1:    return 4'(32'd3 << (addr % 4));
            default: return 4'hF;
        endcase
    endfunction

    // One complete access starting at posedge+1 in IDLE; ack in ACCESS cycle ack_delay (>= TO: none).
    task automatic run_access(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] d2, input logic [31:0] rdata, input int ack_delay,
                              input string tag);
        bit         store = wr;
        bit         illegal = model_illegal(store, f3);
        bit         misal = model_misaligned(f3, addr);
        bit         done = 1'b0;
        logic [1:0] cause = illegal ? 2'b10 : 2'b01;
        mem_read = rd; mem_write = wr; func3 = f3; address = addr; data2 = d2;
        @(negedge clk);
        if (illegal || misal) begin
            tests_run++;
            if ({busywait, fault, fault_cause, bus.dmem_read, bus.dmem_write} !== {2'b01, cause, 2'b00}) begin
                tests_failed++;
                $display("FAIL %s fault: got bw=%b f=%b c=%b rd=%b wr=%b, want bw=0 f=1 c=%b no strobe",
                         tag, busywait, fault, fault_cause, bus.dmem_read, bus.dmem_write, cause);
            end
            @(posedge clk); #1;
            mem_read = 1'b0; mem_write = 1'b0;
            @(negedge clk);
            tests_run++;
            if ({bus.dmem_read, bus.dmem_write, busywait} !== 3'b000 || data_out !== exp_data_out) begin
                tests_failed++;
                $display("FAIL %s after_fault: got rd=%b wr=%b bw=%b dout=%h, want 0 0 0 dout=%h",
                         tag, bus.dmem_read, bus.dmem_write, busywait, data_out, exp_data_out);
            end
            @(posedge clk); #1;
            return;
        end
        tests_run++;
        if ({busywait, fault, fault_cause, bus.dmem_read, bus.dmem_write} !== 6'b100000) begin
            tests_failed++;
            $display("FAIL %s idle_req: got bw=%b f=%b c=%b rd=%b wr=%b, want bw=1 f=0 c=00 no strobe",
                     tag, busywait, fault, fault_cause, bus.dmem_read, bus.dmem_write);
        end
        @(posedge clk); #1;
        for (int k = 0; k < TO && !done; k++) begin
            bus.dmem_ack   = (k == ack_delay);
            bus.dmem_rdata = (k == ack_delay) ? rdata : $urandom;
            @(negedge clk);
            tests_run++;
            if ({busywait, fault, bus.dmem_read, bus.dmem_write} !== {2'b10, !store, store}
                || bus.dmem_addr !== (addr & 32'hFFFF_FFFC)
                || bus.dmem_byte_en !== (store ? model_ben(f3, addr) : 4'h0)
                || (store && bus.dmem_wdata !== model_wdata(f3, d2))) begin
                tests_failed++;
                $display("FAIL %s access%0d: got bw=%b f=%b rd=%b wr=%b a=%h be=%b wd=%h, want bw=1 f=0 rd=%b wr=%b a=%h be=%b wd=%h",
                         tag, k, busywait, fault, bus.dmem_read, bus.dmem_write, bus.dmem_addr,
                         bus.dmem_byte_en, bus.dmem_wdata, !store, store, addr & 32'hFFFF_FFFC,
                         store ? model_ben(f3, addr) : 4'h0, model_wdata(f3, d2));
            end
            if (k == ack_delay) done = 1'b1;
            @(posedge clk); #1;
        end
        bus.dmem_ack = 1'b0;
        if (done && !store) exp_data_out = model_load(f3, addr, rdata);
        @(negedge clk);
        tests_run++;
        if ({busywait, fault, fault_cause, bus.dmem_read, bus.dmem_write} !== {1'b0, !done, (done ? 2'b00 : 2'b11), 2'b00}
            || data_out !== exp_data_out) begin
            tests_failed++;
            $display("FAIL %s done: got bw=%b f=%b c=%b rd=%b wr=%b dout=%h, want bw=0 f=%b c=%b no strobe dout=%h",
                     tag, busywait, fault, fault_cause, bus.dmem_read, bus.dmem_write, data_out,
                     !done, done ? 2'b00 : 2'b11, exp_data_out);
        end
        @(posedge clk); #1;
        mem_read = 1'b0; mem_write = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; func3 = 3'b000; address = '0; data2 = '0;
        bus.dmem_ack = 1'b0; bus.dmem_rdata = '0;
        exp_data_out = 32'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({data_out, bus.dmem_addr, bus.dmem_wdata, bus.dmem_byte_en, bus.dmem_read, bus.dmem_write,
             busywait, fault, fault_cause} !== 104'h0) begin
            tests_failed++;
            $display("FAIL reset: got dout=%h a=%h wd=%h be=%b rd=%b wr=%b bw=%b f=%b c=%b, want all 0",
                     data_out, bus.dmem_addr, bus.dmem_wdata, bus.dmem_byte_en, bus.dmem_read,
                     bus.dmem_write, busywait, fault, fault_cause);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_load_extend();
        run_access(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h8011_2233, 0, "lb");
        tests_run++;
        if (data_out !== 32'hFFFF_FF80) begin
            tests_failed++;
            $display("FAIL lb_const: got %h want FFFFFF80", data_out);
        end
        run_access(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 32'h8011_2233, 1, "lbu");
        tests_run++;
        if (data_out !== 32'h0000_0080) begin
            tests_failed++;
            $display("FAIL lbu_const: got %h want 00000080", data_out);
        end
        run_access(1'b1, 1'b0, 3'b001, 32'h82, 32'h0, 32'h9ABC_0011, 0, "lh");
        run_access(1'b1, 1'b0, 3'b101, 32'h82, 32'h0, 32'h9ABC_0011, 2, "lhu");
        run_access(1'b1, 1'b0, 3'b010, 32'h84, 32'h0, 32'hDEAD_BEEF, 1, "lw");
    endtask

    task automatic test_store_align();
        run_access(1'b0, 1'b1, 3'b001, 32'h202, 32'h1234_ABCD, 32'h0, 2, "sh");
        run_access(1'b0, 1'b1, 3'b000, 32'h301, 32'h55AA_3C96, 32'h0, 0, "sb");
        run_access(1'b1, 1'b1, 3'b010, 32'h300, 32'hCAFE_F00D, 32'h0, 1, "both_sw");
    endtask

    task automatic test_faults();
        run_access(1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 32'h0, 0, "lw_misal");
        run_access(1'b1, 1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 0, "f3_011");
        run_access(1'b0, 1'b1, 3'b100, 32'h100, 32'h0, 32'h0, 0, "sbu_illegal");
        run_access(1'b1, 1'b0, 3'b111, 32'h101, 32'h0, 32'h0, 0, "illegal_prio");
        run_access(1'b0, 1'b1, 3'b001, 32'h103, 32'h0, 32'h0, 0, "sh_misal");
    endtask

    task automatic test_timeout();
        run_access(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 32'h0, TO, "timeout");
        run_access(1'b1, 1'b0, 3'b010, 32'h44, 32'h0, 32'h7654_3210, TO - 1, "ack_at_limit");
    endtask

    task automatic test_reset_mid_access();
        run_access(1'b0, 1'b1, 3'b010, 32'h500, 32'h1111_2222, 32'h0, 2, "store_ack3");
        mem_write = 1'b1; func3 = 3'b010; address = 32'h504; data2 = 32'h3333_4444;
        @(posedge clk); #1;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        exp_data_out = 32'h0;
        tests_run++;
        if ({data_out, bus.dmem_addr, bus.dmem_wdata, bus.dmem_byte_en, bus.dmem_read, bus.dmem_write,
             busywait, fault, fault_cause} !== 104'h0) begin
            tests_failed++;
            $display("FAIL async_reset: got dout=%h a=%h wd=%h be=%b rd=%b wr=%b bw=%b f=%b c=%b, want all 0",
                     data_out, bus.dmem_addr, bus.dmem_wdata, bus.dmem_byte_en, bus.dmem_read,
                     bus.dmem_write, busywait, fault, fault_cause);
        end
        mem_write = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        run_access(1'b1, 1'b0, 3'b000, 32'h506, 32'h0, 32'h00FE_0000, 0, "post_reset_lb");
    endtask

    task automatic test_back_to_back();
        int c0;
        for (int i = 0; i < 2; i++) begin
            c0 = cyc;
            run_access(1'b1, 1'b0, 3'b010, 32'h600 + 32'(4 * i), 32'h0, $urandom, 0, "b2b_lw");
            tests_run++;
            if (cyc - c0 !== 3) begin
                tests_failed++;
                $display("FAIL b2b_cycles: got %0d want 3", cyc - c0);
            end
        end
    endtask

    task automatic test_spurious_ack();
        repeat (2) begin
            bus.dmem_ack = 1'b1; bus.dmem_rdata = $urandom;
            @(negedge clk);
            tests_run++;
            if ({busywait, fault, bus.dmem_read, bus.dmem_write} !== 4'b0000 || data_out !== exp_data_out) begin
                tests_failed++;
                $display("FAIL idle_ack: got bw=%b f=%b rd=%b wr=%b dout=%h, want 0 0 0 0 dout=%h",
                         busywait, fault, bus.dmem_read, bus.dmem_write, data_out, exp_data_out);
            end
            @(posedge clk); #1;
        end
        bus.dmem_ack = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            logic [1:0] op = 2'($urandom_range(1, 3));
            run_access(op[0], op[1], 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
                       int'($urandom_range(0, TO)), "rand");
        end
    endtask

    initial begin
        test_reset();
        test_load_extend();
        test_store_align();
        test_faults();
        test_timeout();
        test_spurious_ack();
        test_reset_mid_access();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
